// File: rtl/mul4_eval_pkg.sv
// Shared types, constants and helpers for the 2x16-bit vector-multiplier fitness harness.
package mul4_eval_pkg;

  localparam int LIMB_W = 16;
  localparam int PROD_W = 64;
  localparam int OPND_W = 2 * LIMB_W;

  // Fibonacci taps 64,63,61,60 expressed as a mask over bits [63:0].
  localparam logic [PROD_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MULT,
    SCORE,
    DONE
  } state_t;

  function automatic logic [6:0] popcount64(input logic [PROD_W-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < PROD_W; i++) begin
      c = c + {6'b0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [PROD_W-1:0] lfsr_step(input logic [PROD_W-1:0] s);
    return {s[PROD_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mul4_seq_multiplier.sv
// 32x32 shift-add multiplier: one partial-product step per clock, 32 steps per operation.
import mul4_eval_pkg::*;

// Handshake: start is a one-cycle load strobe (operands captured, product cleared);
// done is high during the final step, so product is valid from the next cycle on
// and holds until the next start.
module mul4_seq_multiplier (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] mcand;
  logic [OPND_W-1:0] mplier;
  logic [4:0]        bit_cnt;
  logic              running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      bit_cnt <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{(PROD_W-OPND_W){1'b0}}, a};
      mplier  <= b;
      product <= '0;
      bit_cnt <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      bit_cnt <= bit_cnt + 5'd1;
      if (bit_cnt == 5'd31) begin
        running <= 1'b0;
      end
    end
  end

  assign done = running && (bit_cnt == 5'd31);

endmodule

// File: rtl/mul4_fitness_evaluator.sv
// Fitness harness: drives LFSR operands into a combinational candidate multiplier and
// scores its 64-bit result bit-by-bit against a sequential golden product.
import mul4_eval_pkg::*;

module mul4_fitness_evaluator #(
  parameter int          N_VECTORS = 16,
  parameter logic [63:0] SEED      = 64'hACE1_0F0F_1234_5678,
  parameter int          FIT_W     = $clog2(64*N_VECTORS+1),
  parameter int          CNT_W     = $clog2(N_VECTORS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      seed_i,
  output logic             busy,
  output logic             done,
  output logic [15:0]      drive_a1,
  output logic [15:0]      drive_a0,
  output logic [15:0]      drive_b1,
  output logic [15:0]      drive_b0,
  input  logic [15:0]      cand_y3,
  input  logic [15:0]      cand_y2,
  input  logic [15:0]      cand_y1,
  input  logic [15:0]      cand_y0,
  output logic [FIT_W-1:0] fitness,
  output logic [CNT_W-1:0] exact_count
);

  state_t            state, state_next;
  logic [PROD_W-1:0] lfsr;
  logic [CNT_W-1:0]  vec_idx;
  logic              mul_start;
  logic              mul_done;
  logic [PROD_W-1:0] ref_prod;
  logic [PROD_W-1:0] cand_y;
  logic [PROD_W-1:0] diff;
  logic [6:0]        err_bits;
  logic              last_vec;

  // Operands go to the multiplier in the same cycle they are latched onto the drive ports.
  mul4_seq_multiplier u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (lfsr[63:32]),
    .b       (lfsr[31:0]),
    .done    (mul_done),
    .product (ref_prod)
  );

  assign cand_y   = {cand_y3, cand_y2, cand_y1, cand_y0};
  assign diff     = cand_y ^ ref_prod;
  assign err_bits = popcount64(diff);
  assign last_vec = (vec_idx == CNT_W'(N_VECTORS - 1));

  assign busy = (state == LOAD) || (state == MULT) || (state == SCORE);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD: begin
        mul_start  = 1'b1;
        state_next = MULT;
      end
      MULT:    if (mul_done) state_next = SCORE;
      SCORE:   state_next = last_vec ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= '0;
      vec_idx     <= '0;
      fitness     <= '0;
      exact_count <= '0;
      drive_a1    <= '0;
      drive_a0    <= '0;
      drive_b1    <= '0;
      drive_b0    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            lfsr        <= (seed_i != '0) ? seed_i : SEED;
            fitness     <= '0;
            exact_count <= '0;
            vec_idx     <= '0;
          end
        end
        LOAD: begin
          drive_a1 <= lfsr[63:48];
          drive_a0 <= lfsr[47:32];
          drive_b1 <= lfsr[31:16];
          drive_b0 <= lfsr[15:0];
        end
        // Stepping only here gives each vector fresh bits without disturbing the drives.
        MULT: lfsr <= lfsr_step(lfsr);
        SCORE: begin
          fitness <= fitness + FIT_W'(7'd64 - err_bits);
          if (diff == '0) begin
            exact_count <= exact_count + CNT_W'(1);
          end
          if (!last_vec) begin
            vec_idx <= vec_idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
